// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared encodings for the CPU run-control sequencer
package cpu_dbg_pkg;
    typedef enum logic [1:0] {ST_HALT = 2'd0, ST_RUN = 2'd1, ST_STEP = 2'd2} state_t;
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_HALT    = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_SET_BP  = 3'd4;
    localparam logic [2:0] OP_CLR_BP  = 3'd5;
    localparam logic [2:0] OP_CLR_CNT = 3'd6;
    localparam logic [1:0] CAUSE_HOST = 2'd0;
    localparam logic [1:0] CAUSE_BP   = 2'd1;
    localparam logic [1:0] CAUSE_STEP = 2'd2;
    localparam logic [1:0] CAUSE_STOP = 2'd3;
    // Coincident halt events resolve STOP > BP > HOST > STEP_DONE.
    function automatic logic [1:0] pick_cause(input logic stop, input logic bp, input logic host);
        return stop ? CAUSE_STOP : bp ? CAUSE_BP : host ? CAUSE_HOST : CAUSE_STEP;
    endfunction
endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: host command handshake into the run-control sequencer
interface cpu_run_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_idx;
    logic [31:0] cmd_arg;
    modport master (output cmd_valid, cmd_op, cmd_idx, cmd_arg, input cmd_ready);
    modport slave (input cmd_valid, cmd_op, cmd_idx, cmd_arg, output cmd_ready);
endinterface

// File: rtl/cpu_run_ctrl_bp_match.sv
// bp_match: PC breakpoint registers with a parallel address comparator
module bp_match #(
    parameter int NUM_BP = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        set,
    input  logic        clr,
    input  logic [2:0]  idx,
    input  logic [31:0] addr,
    input  logic [31:0] pc,
    output logic        hit
);
    logic [31:0] bp [NUM_BP];
    logic        en [NUM_BP];
    logic [NUM_BP-1:0] m;
    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        // Load or disable this slot; indices beyond NUM_BP match no slot and are dropped.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                bp[i] <= '0;
                en[i] <= 1'b0;
            end else if (idx == 3'(i) && (set || clr)) begin
                bp[i] <= set ? addr : bp[i];
                en[i] <= set;
            end
        end
        assign m[i] = en[i] && pc == bp[i];
    end
    assign hit = |m;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/step sequencer driving the core clock-enable
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int NUM_BP = 2,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    cpu_run_ctrl_if.slave     cmd,
    input  logic [31:0]       pc,
    input  logic              cpu_stop,
    output logic              cpu_en,
    output logic              halted,
    output logic              dbg_grant,
    output logic [1:0]        halt_cause,
    output logic [STEP_W-1:0] step_left,
    output logic [CNT_W-1:0]  cycle_cnt
);
    state_t state, state_nx;
    logic   skip, acc, hit, ev_bp, ev_host, ev_done, ev;
    logic   go_run, go_step, bp_set, bp_clr, cnt_clr;
    assign halted        = state == ST_HALT;
    assign cpu_en        = !halted;
    assign dbg_grant     = halted;
    assign cmd.cmd_ready = halted || cmd.cmd_op == OP_HALT;
    assign acc           = cmd.cmd_valid && cmd.cmd_ready;
    assign go_run        = halted && acc && cmd.cmd_op == OP_RUN;
    assign go_step       = halted && acc && cmd.cmd_op == OP_STEP;
    assign bp_set        = halted && acc && cmd.cmd_op == OP_SET_BP;
    assign bp_clr        = halted && acc && cmd.cmd_op == OP_CLR_BP;
    assign cnt_clr       = halted && acc && cmd.cmd_op == OP_CLR_CNT;
    assign ev_bp         = hit && !skip;
    assign ev_host       = acc && cmd.cmd_op == OP_HALT;
    assign ev_done       = state == ST_STEP && step_left == STEP_W'(1);
    assign ev            = cpu_en && (cpu_stop || ev_bp || ev_host || ev_done);
    bp_match #(.NUM_BP(NUM_BP)) u_bp (
        .clk  (clk),
        .rstn (rstn),
        .set  (bp_set),
        .clr  (bp_clr),
        .idx  (cmd.cmd_idx),
        .addr (cmd.cmd_arg),
        .pc   (pc),
        .hit  (hit)
    );
    // Any halt event wins; otherwise only an accepted RUN/STEP leaves HALT.
    always_comb begin
        state_nx = ev ? ST_HALT : go_run ? ST_RUN : go_step ? ST_STEP : state;
    end
    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_HALT;
        else       state <= state_nx;
    end
    // skip marks the first enabled cycle after HALT so a resume from a breakpoint PC advances.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            skip       <= 1'b1;
            halt_cause <= CAUSE_HOST;
            step_left  <= '0;
            cycle_cnt  <= '0;
        end else begin
            skip       <= halted;
            halt_cause <= ev ? pick_cause(cpu_stop, ev_bp, ev_host) : halt_cause;
            step_left  <= ev ? '0
                        : state == ST_STEP ? step_left - STEP_W'(1)
                        : go_step ? (cmd.cmd_arg[STEP_W-1:0] == '0 ? STEP_W'(1) : cmd.cmd_arg[STEP_W-1:0])
                        : step_left;
            cycle_cnt  <= cnt_clr ? '0 : cpu_en ? cycle_cnt + CNT_W'(1) : cycle_cnt;
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed and randomized checks of cpu_run_ctrl against a behavioural model
module tb_cpu_run_ctrl;
    localparam int NB = 2;
    localparam int SW = 8;
    localparam int CW = 10;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    cpu_run_ctrl_if ifc();
    logic [31:0]   pc = '0;
    logic          cpu_stop = 1'b0;
    logic          cpu_en, halted, dbg_grant;
    logic [1:0]    halt_cause;
    logic [SW-1:0] step_left;
    logic [CW-1:0] cycle_cnt;
    cpu_run_ctrl #(.NUM_BP(NB), .STEP_W(SW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd        (ifc),
        .pc         (pc),
        .cpu_stop   (cpu_stop),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .dbg_grant  (dbg_grant),
        .halt_cause (halt_cause),
        .step_left  (step_left),
        .cycle_cnt  (cycle_cnt)
    );
    // Model: mode 0 halted, 1 running, 2 stepping.
    int m_mode, m_left, m_cnt, m_cause;
    bit m_first;
    int m_bp [NB];
    bit m_en [NB];
    int n_chk = 0;
    int n_fail = 0;
    task chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task model_step();
        int op;
        bit acc, hitbp, host, done;
        op = int'(ifc.cmd_op);
        if (!rstn) begin
            m_mode = 0; m_left = 0; m_cnt = 0; m_cause = 0; m_first = 1;
            for (int i = 0; i < NB; i++) begin m_bp[i] = 0; m_en[i] = 0; end
            return;
        end
        acc = ifc.cmd_valid && (m_mode == 0 || op == 2);
        if (m_mode != 0) begin
            hitbp = 0;
            for (int i = 0; i < NB; i++) if (m_en[i] && m_bp[i] == int'(pc)) hitbp = 1;
            hitbp = hitbp && !m_first;
            host = acc && op == 2;
            done = m_mode == 2 && m_left == 1;
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_first = 0;
            if (cpu_stop || hitbp || host || done) begin
                m_cause = cpu_stop ? 3 : hitbp ? 1 : host ? 0 : 2;
                m_mode = 0;
                m_left = 0;
            end else if (m_mode == 2) m_left = m_left - 1;
        end else begin
            m_first = 1;
            if (acc) case (op)
                1: m_mode = 1;
                3: begin m_mode = 2; m_left = int'(ifc.cmd_arg[SW-1:0]); if (m_left == 0) m_left = 1; end
                4: if (int'(ifc.cmd_idx) < NB) begin m_bp[ifc.cmd_idx] = int'(ifc.cmd_arg); m_en[ifc.cmd_idx] = 1; end
                5: if (int'(ifc.cmd_idx) < NB) m_en[ifc.cmd_idx] = 0;
                6: m_cnt = 0;
                default: ;
            endcase
        end
    endtask
    task check_all();
        chk("cpu_en", cpu_en, m_mode != 0);
        chk("halted", halted, m_mode == 0);
        chk("dbg_grant", dbg_grant, m_mode == 0);
        chk("halt_cause", halt_cause, m_cause);
        chk("step_left", step_left, m_left);
        chk("cycle_cnt", cycle_cnt, m_cnt);
        chk("cmd_ready", ifc.cmd_ready, m_mode == 0 || ifc.cmd_op == 3'd2);
    endtask
    task cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask
    task cmd(input logic [2:0] op, input logic [2:0] idx, input logic [31:0] arg);
        ifc.cmd_valid = 1'b1; ifc.cmd_op = op; ifc.cmd_idx = idx; ifc.cmd_arg = arg;
        cyc();
        ifc.cmd_valid = 1'b0; ifc.cmd_op = 3'd0;
    endtask
    initial begin
        ifc.cmd_valid = 1'b0; ifc.cmd_op = '0; ifc.cmd_idx = '0; ifc.cmd_arg = '0;
        repeat (2) cyc();
        rstn = 1'b1;
        repeat (10) cyc();
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_halted", halted, 1);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cnt", cycle_cnt, 0);
        chk("rst_ready", ifc.cmd_ready, 1);
        pc = 32'h10;
        cmd(3'd3, 3'd0, 32'd3);
        chk("step3_left_a", step_left, 3);
        cyc();
        chk("step3_left_b", step_left, 2);
        cyc();
        chk("step3_left_c", step_left, 1);
        cyc();
        chk("step3_halted", halted, 1);
        chk("step3_left_end", step_left, 0);
        chk("step3_cause", halt_cause, 2);
        chk("step3_cnt", cycle_cnt, 3);
        cmd(3'd3, 3'd0, 32'd0);
        chk("step0_en", cpu_en, 1);
        cyc();
        chk("step0_halted", halted, 1);
        chk("step0_cnt", cycle_cnt, 4);
        cmd(3'd4, 3'd0, 32'h20);
        cmd(3'd1, 3'd0, 32'd0);
        repeat (3) cyc();
        pc = 32'h20;
        cyc();
        chk("bp_halted", halted, 1);
        chk("bp_cause", halt_cause, 1);
        cmd(3'd1, 3'd0, 32'd0);
        chk("resume_en", cpu_en, 1);
        cyc();
        chk("resume_skip_en", cpu_en, 1);
        pc = 32'h24;
        repeat (2) cyc();
        ifc.cmd_valid = 1'b1; ifc.cmd_op = 3'd4; ifc.cmd_idx = 3'd1; ifc.cmd_arg = 32'h40;
        #1 chk("stall_ready", ifc.cmd_ready, 0);
        repeat (3) cyc();
        chk("stall_still_run", cpu_en, 1);
        ifc.cmd_op = 3'd2;
        #1 chk("halt_ready", ifc.cmd_ready, 1);
        cyc();
        ifc.cmd_valid = 1'b0; ifc.cmd_op = 3'd0;
        chk("host_halted", halted, 1);
        chk("host_cause", halt_cause, 0);
        cmd(3'd6, 3'd0, 32'd0);
        chk("clr_cnt", cycle_cnt, 0);
        pc = 32'h10;
        cmd(3'd3, 3'd0, 32'd5);
        cyc();
        chk("stop_left_mid", step_left, 4);
        pc = 32'h20; cpu_stop = 1'b1;
        cyc();
        cpu_stop = 1'b0;
        chk("stop_halted", halted, 1);
        chk("stop_cause", halt_cause, 3);
        chk("stop_left", step_left, 0);
        chk("stop_cnt", cycle_cnt, 2);
        cmd(3'd6, 3'd0, 32'd0);
        pc = 32'h100;
        cmd(3'd1, 3'd0, 32'd0);
        repeat ((1 << CW) - 1) cyc();
        chk("wrap_ones", cycle_cnt, (1 << CW) - 1);
        cyc();
        chk("wrap_zero", cycle_cnt, 0);
        chk("wrap_running", cpu_en, 1);
        repeat ((1 << CW) - 1) cyc();
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        chk("midrst_halted", halted, 1);
        chk("midrst_cnt", cycle_cnt, 0);
        chk("midrst_en", cpu_en, 0);
        pc = 32'h20;
        cmd(3'd1, 3'd0, 32'd0);
        repeat (3) cyc();
        chk("bp_cleared_run", cpu_en, 1);
        cmd(3'd2, 3'd0, 32'd0);
        for (int n = 0; n < 600; n++) begin
            rstn = $urandom_range(0, 99) != 0;
            ifc.cmd_valid = $urandom_range(0, 2) == 0;
            ifc.cmd_op = 3'($urandom_range(0, 6));
            ifc.cmd_idx = 3'($urandom_range(0, 3));
            ifc.cmd_arg = ifc.cmd_op == 3'd3 ? ($urandom_range(0, 6) | ($urandom_range(0, 3) == 0 ? 32'h100 : 32'h0))
                        : 32'h20 + 32'($urandom_range(0, 3)) * 4;
            pc = 32'h20 + 32'($urandom_range(0, 3)) * 4;
            cpu_stop = $urandom_range(0, 30) == 0;
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
